// File: rtl/alu_sequencer_if.sv
// Command/response handshake plus the operand/result bus to the external ALU.
// The sequencer connects through the slave modport. The command source, the
// response sink and the ALU connect through the master modport.
interface alu_sequencer_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_opcode;
  logic [BUS_WIDTH-1:0] cmd_operand;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUS_WIDTH-1:0] rsp_result;
  logic [4:0]           rsp_flags;

  logic [3:0]           alu_opcode;
  logic [BUS_WIDTH-1:0] alu_a;
  logic [BUS_WIDTH-1:0] alu_b;
  logic                 alu_carry_in;
  logic [BUS_WIDTH-1:0] alu_y;
  logic                 alu_carry_out;
  logic                 alu_borrow;
  logic                 alu_zero;
  logic                 alu_parity;
  logic                 alu_invalid_op;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    input  alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags,
    output alu_opcode, alu_a, alu_b, alu_carry_in
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    output alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags,
    input  alu_opcode, alu_a, alu_b, alu_carry_in
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator sequencer. It latches one command, drives a combinational external
// ALU for one cycle, captures the result and flags, and holds the response until
// the consumer accepts it.
module alu_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] OP_LOAD = 4'hF;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_ready;
  logic [BUS_WIDTH-1:0] r_acc;
  logic                 r_carry;
  logic [4:0]           r_flags;
  logic [3:0]           r_opcode;
  logic [BUS_WIDTH-1:0] r_operand;

  logic                 w_accept;
  logic                 w_rsp_done;
  logic [4:0]           w_load_flags;
  logic [4:0]           w_alu_flags;

  assign w_accept     = (r_state == S_IDLE) && r_ready && bus.cmd_valid;
  assign w_rsp_done   = (r_state == S_RESP) && bus.rsp_ready;
  assign w_load_flags = {1'b0, ^r_operand, (r_operand == '0), 2'b00};
  assign w_alu_flags  = {bus.alu_invalid_op, bus.alu_parity, bus.alu_zero,
                         bus.alu_borrow, bus.alu_carry_out};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_flags   <= 5'b0;
      r_opcode  <= 4'h0;
      r_operand <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == S_IDLE);
      if (w_accept) begin
        r_opcode  <= bus.cmd_opcode;
        r_operand <= bus.cmd_operand;
      end
      if (r_state == S_EXEC) begin
        if (r_opcode == OP_LOAD) begin
          r_acc   <= r_operand;
          r_carry <= 1'b0;
          r_flags <= w_load_flags;
        end else if (bus.alu_invalid_op) begin
          r_flags <= 5'b10000;
        end else begin
          r_acc   <= bus.alu_y;
          r_carry <= bus.alu_carry_out;
          r_flags <= w_alu_flags;
        end
      end
    end
  end

  assign bus.cmd_ready    = r_ready;
  assign bus.rsp_valid    = (r_state == S_RESP);
  assign bus.rsp_result   = r_acc;
  assign bus.rsp_flags    = r_flags;
  assign bus.alu_opcode   = r_opcode;
  assign bus.alu_a        = r_acc;
  assign bus.alu_b        = r_operand;
  assign bus.alu_carry_in = r_carry;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. It provides a reference ALU, a per-cycle
// compare process driven by a transaction-level model, and literal checks.
module tb_alu_sequencer;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BUS_WIDTH(BW)) bus();
  alu_sequencer #(.BUS_WIDTH(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference ALU packs {invalid, carry_out, borrow, y}. LOAD and unknown
  // opcodes return junk so the sequencer is seen to ignore it.
  function automatic logic [BW+2:0] alu_fn(input logic [3:0] op, input logic [BW-1:0] a,
                                           input logic [BW-1:0] b, input logic cin);
    logic [BW:0] s;
    logic [BW+2:0] r;
    s = '0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = {1'b0, s[BW], 1'b0, s[BW-1:0]}; end
      4'd2: begin s = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, cin}; r = {1'b0, s[BW], 1'b0, s[BW-1:0]}; end
      4'd3: r = {1'b0, 1'b0, (a < b), a - b};
      4'd4: r = {3'b000, a & b};
      4'd5: r = {3'b000, a | b};
      4'd6: r = {3'b000, a ^ b};
      4'd15: r = {3'b011, BW'(90)};
      default: r = {3'b111, BW'(238)};
    endcase
    return r;
  endfunction

  logic [BW+2:0] alu_r;
  assign alu_r              = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
  assign bus.alu_y          = alu_r[BW-1:0];
  assign bus.alu_borrow     = alu_r[BW];
  assign bus.alu_carry_out  = alu_r[BW+1];
  assign bus.alu_invalid_op = alu_r[BW+2];
  assign bus.alu_zero       = alu_r[BW+2] ? 1'b1 : (alu_r[BW-1:0] == '0);
  assign bus.alu_parity     = alu_r[BW+2] ? 1'b1 : ^alu_r[BW-1:0];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  logic [BW-1:0] m_acc;
  logic          m_c;
  logic          m_busy = 1'b0;
  logic          m_check_en = 1'b0;
  int            m_accept = 0;
  logic [3:0]    m_x_op;
  logic [BW-1:0] m_x_a;
  logic [BW-1:0] m_x_b;
  logic          m_x_c;
  logic [BW-1:0] m_exp_res;
  logic [4:0]    m_exp_flags;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare. Phase 0 is the cycle in which the command is offered,
  // phase 1 is EXEC, and phase 2 onwards is RESP.
  always @(negedge clk) begin
    if (m_check_en) begin
      if (!m_busy) begin
        chk("idle_cmd_ready", {31'b0, bus.cmd_ready}, 1);
        chk("idle_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("idle_alu_a", {24'b0, bus.alu_a}, {24'b0, m_acc});
        chk("idle_alu_cin", {31'b0, bus.alu_carry_in}, {31'b0, m_c});
      end else if (cyc - m_accept == 0) begin
        chk("offer_cmd_ready", {31'b0, bus.cmd_ready}, 1);
        chk("offer_rsp_valid", {31'b0, bus.rsp_valid}, 0);
      end else if (cyc - m_accept == 1) begin
        chk("exec_cmd_ready", {31'b0, bus.cmd_ready}, 0);
        chk("exec_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("exec_alu_opcode", {28'b0, bus.alu_opcode}, {28'b0, m_x_op});
        chk("exec_alu_a", {24'b0, bus.alu_a}, {24'b0, m_x_a});
        chk("exec_alu_b", {24'b0, bus.alu_b}, {24'b0, m_x_b});
        chk("exec_alu_cin", {31'b0, bus.alu_carry_in}, {31'b0, m_x_c});
      end else begin
        chk("resp_cmd_ready", {31'b0, bus.cmd_ready}, 0);
        chk("resp_rsp_valid", {31'b0, bus.rsp_valid}, 1);
        chk("resp_result", {24'b0, bus.rsp_result}, {24'b0, m_exp_res});
        chk("resp_flags", {27'b0, bus.rsp_flags}, {27'b0, m_exp_flags});
      end
    end
  end

  logic [BW-1:0] last_res;
  logic [4:0]    last_flags;
  logic          last_exec_cin;

  task automatic model_accept(input logic [3:0] op, input logic [BW-1:0] opnd);
    logic [BW+2:0] r;
    m_x_op = op; m_x_a = m_acc; m_x_b = opnd; m_x_c = m_c;
    if (op == 4'd15) begin
      m_acc = opnd; m_c = 1'b0;
      m_exp_flags = {1'b0, ^opnd, (opnd == '0), 2'b00};
    end else begin
      r = alu_fn(op, m_acc, opnd, m_c);
      if (r[BW+2]) begin
        m_exp_flags = 5'b10000;
      end else begin
        m_acc = r[BW-1:0]; m_c = r[BW+1];
        m_exp_flags = {1'b0, ^r[BW-1:0], (r[BW-1:0] == '0), r[BW], r[BW+1]};
      end
    end
    m_exp_res = m_acc;
    m_accept = cyc;
    m_busy = 1'b1;
  endtask

  task automatic transact(input logic [3:0] op, input logic [BW-1:0] opnd,
                          input int hold, input bit extra);
    int t;
    @(posedge clk); #1;
    bus.cmd_opcode = op; bus.cmd_operand = opnd; bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cmd_ready got 0, expected 1 op=%0d", op);
      bus.cmd_valid = 1'b0;
      return;
    end
    model_accept(op, opnd);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    last_exec_cin = bus.alu_carry_in;
    if (extra) begin
      bus.cmd_valid = 1'b1; bus.cmd_opcode = 4'd15; bus.cmd_operand = BW'(119);
    end
    t = 0;
    while (!bus.rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
    if (!bus.rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid got 0, expected 1 op=%0d", op);
      bus.cmd_valid = 1'b0;
      m_busy = 1'b0;
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    last_res = bus.rsp_result;
    last_flags = bus.rsp_flags;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    m_busy = 1'b0;
    $display("txn op=%0d operand=%0d -> result=%0d flags=%05b", op, opnd, last_res, last_flags);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, bus.cmd_ready}, 0);
    chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 0);
    chk({tag, "_rsp_result"}, {24'b0, bus.rsp_result}, 0);
    chk({tag, "_rsp_flags"}, {27'b0, bus.rsp_flags}, 0);
    chk({tag, "_alu_opcode"}, {28'b0, bus.alu_opcode}, 0);
    chk({tag, "_alu_a"}, {24'b0, bus.alu_a}, 0);
    chk({tag, "_alu_b"}, {24'b0, bus.alu_b}, 0);
    chk({tag, "_alu_cin"}, {31'b0, bus.alu_carry_in}, 0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1 chk("post_rst_ready_low", {31'b0, bus.cmd_ready}, 0);
    @(posedge clk); #1;
    chk("post_rst_ready_high", {31'b0, bus.cmd_ready}, 1);
    chk("post_rst_acc", {24'b0, bus.rsp_result}, 0);
    m_acc = '0; m_c = 1'b0; m_busy = 1'b0; m_check_en = 1'b1;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 4'h0; bus.cmd_operand = '0; bus.rsp_ready = 1'b0;
    #12 chk_all_zero("reset");
    release_reset();

    // Basic add, with rsp_valid exactly two cycles after accept.
    transact(4'd15, 8'd9, 0, 1'b0);
    chk("load9_res", {24'b0, last_res}, 9);
    chk("load9_flags", {27'b0, last_flags}, 5'b00000);
    transact(4'd1, 8'd33, 0, 1'b0);
    chk("add33_res", {24'b0, last_res}, 42);
    chk("add33_flags", {27'b0, last_flags}, 5'b01000);

    // Carry out, then add-with-carry consuming it.
    transact(4'd15, 8'd200, 0, 1'b0);
    transact(4'd1, 8'd100, 0, 1'b0);
    chk("add100_res", {24'b0, last_res}, 44);
    chk("add100_flags", {27'b0, last_flags}, 5'b01001);
    transact(4'd2, 8'd0, 0, 1'b0);
    chk("adc_exec_cin", {31'b0, last_exec_cin}, 1);
    chk("adc_res", {24'b0, last_res}, 45);
    chk("adc_flags", {27'b0, last_flags}, 5'b00000);

    // Subtraction with and without borrow.
    transact(4'd15, 8'd65, 0, 1'b0);
    transact(4'd3, 8'd66, 0, 1'b0);
    chk("sub66_res", {24'b0, last_res}, 255);
    chk("sub66_flags", {27'b0, last_flags}, 5'b00010);
    transact(4'd15, 8'd65, 0, 1'b0);
    transact(4'd3, 8'd64, 0, 1'b0);
    chk("sub64_res", {24'b0, last_res}, 1);
    chk("sub64_flags", {27'b0, last_flags}, 5'b01000);

    // An invalid opcode leaves the accumulator intact.
    transact(4'd15, 8'd5, 0, 1'b0);
    transact(4'd0, 8'd3, 0, 1'b0);
    chk("inv_res", {24'b0, last_res}, 5);
    chk("inv_flags", {27'b0, last_flags}, 5'b10000);
    transact(4'd1, 8'd1, 0, 1'b0);
    chk("after_inv_res", {24'b0, last_res}, 6);

    // Response back-pressure, with a stray command that must be ignored.
    transact(4'd15, 8'd3, 0, 1'b0);
    transact(4'd1, 8'd4, 5, 1'b1);
    chk("hold_res", {24'b0, last_res}, 7);
    chk("hold_flags", {27'b0, last_flags}, 5'b01000);
    transact(4'd1, 8'd1, 0, 1'b0);
    chk("after_hold_res", {24'b0, last_res}, 8);

    // Reset asserted in EXEC aborts the operation.
    transact(4'd15, 8'd10, 0, 1'b0);
    m_check_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_ready", {31'b0, bus.cmd_ready}, 1);
    bus.cmd_opcode = 4'd1; bus.cmd_operand = 8'd5; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("rst_exec_opcode", {28'b0, bus.alu_opcode}, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midexec_rst");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (4) @(posedge clk);
    transact(4'd1, 8'd7, 0, 1'b0);
    chk("post_abort_res", {24'b0, last_res}, 7);
    chk("post_abort_flags", {27'b0, last_flags}, 5'b01000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
